intc_cpu_evt: RTL and testbench

CPU-side event issuer of the interrupt controller. Takes the winning request from the priority-selection tree, filters it against the CPU's current interrupt mask level, and presents it to the CPU as a level plus vector. It then runs the acknowledge handshake and emits a one-cycle clear back to the request sources. The block then holds off re-issue until the clear has propagated back through the selection tree. One instance sits per CPU, between the last selection stage and the CPU event port.

---
 rtl/intc_pkg.sv | 20 ++
 rtl/intc_pri_gt.sv | 17 +
 rtl/intc_cpu_evt.sv | 108 ++++++++++
 tb/tb_intc_cpu_evt.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// intc_pkg : shared types and widths for the interrupt controller
// rev 1.0
// ------------------------------------------------------------------
package intc_pkg;

  localparam int INTC_PRI_DW = 4;
  localparam int INTC_VEC_DW = 8;
  localparam int INTC_HCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CLR  = 2'd2,
    ST_HOLD = 2'd3
  } intc_evt_st_e;

endpackage
`default_nettype wire

// File: rtl/intc_pri_gt.sv
`default_nettype none
// ------------------------------------------------------------------
// intc_pri_gt : unsigned W-bit greater-than comparator (a > b)
// rev 1.0
// ------------------------------------------------------------------
module intc_pri_gt #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule
`default_nettype wire

// File: rtl/intc_cpu_evt.sv
`default_nettype none
// ------------------------------------------------------------------
// intc_cpu_evt : mask-filtered CPU event issuer with ack/clear/hold-off
// rev 1.0
// ------------------------------------------------------------------
module intc_cpu_evt
  import intc_pkg::*;
#(
  parameter int PRI_DW   = INTC_PRI_DW,
  parameter int VEC_DW   = INTC_VEC_DW,
  parameter int HOLD_CYC = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PRI_DW+VEC_DW-1:0] req_dat_i,
  input  logic [PRI_DW-1:0]        imask_i,
  input  logic                     cpu_ack_i,
  output logic                     irq_o,
  output logic [PRI_DW-1:0]        irq_lvl_o,
  output logic [VEC_DW-1:0]        irq_vec_o,
  output logic                     clr_o,
  output logic [VEC_DW-1:0]        clr_vec_o,
  output logic                     busy_o
);

  localparam int DW = PRI_DW + VEC_DW;
  localparam logic [INTC_HCNT_W-1:0] HOLD_LOAD = INTC_HCNT_W'(HOLD_CYC - 1);

  intc_evt_st_e            state;
  logic [PRI_DW-1:0]       lvl_q;
  logic [VEC_DW-1:0]       vec_q;
  logic [INTC_HCNT_W-1:0]  hold_cnt;

  logic [PRI_DW-1:0]       req_pri;
  logic [VEC_DW-1:0]       req_vec;
  logic                    pri_gt_mask;
  logic                    pri_gt_lvl;
  logic                    elig;

  assign req_pri = req_dat_i[DW-1:VEC_DW];
  assign req_vec = req_dat_i[VEC_DW-1:0];

  intc_pri_gt #(.W(PRI_DW)) u_gt_mask (
    .a  (req_pri),
    .b  (imask_i),
    .gt (pri_gt_mask)
  );

  intc_pri_gt #(.W(PRI_DW)) u_gt_lvl (
    .a  (req_pri),
    .b  (lvl_q),
    .gt (pri_gt_lvl)
  );

  assign elig = (req_pri != '0) && pri_gt_mask;

  // Ack is checked first so the latched event is cleared even if the
  // request is withdrawn or preempted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lvl_q    <= '0;
      vec_q    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig) begin
            lvl_q <= req_pri;
            vec_q <= req_vec;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cpu_ack_i) begin
            state <= ST_CLR;
          end else if (elig && pri_gt_lvl) begin
            lvl_q <= req_pri;
            vec_q <= req_vec;
          end else if (!elig) begin
            state <= ST_IDLE;
          end
        end
        ST_CLR: begin
          hold_cnt <= HOLD_LOAD;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_o     = (state == ST_REQ);
  assign irq_lvl_o = (state == ST_REQ) ? lvl_q : '0;
  assign irq_vec_o = (state == ST_REQ) ? vec_q : '0;
  assign clr_o     = (state == ST_CLR);
  assign clr_vec_o = (state == ST_CLR) ? vec_q : '0;
  assign busy_o    = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_intc_cpu_evt.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_intc_cpu_evt : directed self-checking bench for intc_cpu_evt
// rev 1.0
// ------------------------------------------------------------------
module tb_intc_cpu_evt;

  localparam int PRI_DW   = 4;
  localparam int VEC_DW   = 8;
  localparam int HOLD_CYC = 3;

  logic                     clk;
  logic                     rst_n;
  logic [PRI_DW+VEC_DW-1:0] req_dat;
  logic [PRI_DW-1:0]        imask;
  logic                     cpu_ack;
  logic                     irq;
  logic [PRI_DW-1:0]        irq_lvl;
  logic [VEC_DW-1:0]        irq_vec;
  logic                     clr;
  logic [VEC_DW-1:0]        clr_vec;
  logic                     busy;

  int total;
  int bad;
  int low_cnt;

  intc_cpu_evt #(
    .PRI_DW   (PRI_DW),
    .VEC_DW   (VEC_DW),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_dat_i (req_dat),
    .imask_i   (imask),
    .cpu_ack_i (cpu_ack),
    .irq_o     (irq),
    .irq_lvl_o (irq_lvl),
    .irq_vec_o (irq_vec),
    .clr_o     (clr),
    .clr_vec_o (clr_vec),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] p, input logic [7:0] v);
    req_dat = {p, v};
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    req_dat = '0;
    imask   = '0;
    cpu_ack = 1'b0;
    step();
    step();
    chk("rst_irq", irq, 0);
    chk("rst_lvl", irq_lvl, 0);
    chk("rst_vec", irq_vec, 0);
    chk("rst_clr", clr, 0);
    chk("rst_clrvec", clr_vec, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // basic issue, ack, clear, hold-off
    imask = 4'd3;
    req(4'd5, 8'h40);
    step();
    chk("basic_irq", irq, 1);
    chk("basic_lvl", irq_lvl, 5);
    chk("basic_vec", irq_vec, 8'h40);
    chk("basic_busy", busy, 1);
    cpu_ack = 1'b1;
    step();                                  // m+1
    cpu_ack = 1'b0;
    req(4'd0, 8'h00);
    chk("ack_clr", clr, 1);
    chk("ack_clrvec", clr_vec, 8'h40);
    chk("ack_irq", irq, 0);
    step();                                  // m+2
    chk("ack_clr_fall", clr, 0);
    chk("ack_busy_m2", busy, 1);
    step();
    step();                                  // m+4
    chk("ack_busy_m4", busy, 1);
    step();                                  // m+5
    chk("ack_busy_m5", busy, 0);

    // mask filter: pri must strictly exceed the mask
    imask = 4'd5;
    req(4'd5, 8'h40);
    step();
    step();
    chk("mask_block", irq, 0);
    imask = 4'd4;
    step();
    chk("mask_open", irq, 1);
    chk("mask_lvl", irq_lvl, 5);

    // preemption by strictly higher priority only
    req(4'd9, 8'h21);
    step();
    chk("pre_irq", irq, 1);
    chk("pre_lvl", irq_lvl, 9);
    chk("pre_vec", irq_vec, 8'h21);
    req(4'd5, 8'h22);
    step();
    chk("pre_low_irq", irq, 1);
    chk("pre_low_lvl", irq_lvl, 9);
    chk("pre_low_vec", irq_vec, 8'h21);

    // withdraw without ack: no clear
    req(4'd0, 8'h00);
    step();
    chk("wd_irq", irq, 0);
    chk("wd_clr", clr, 0);
    chk("wd_busy", busy, 0);
    step();
    chk("wd_clr2", clr, 0);

    // withdraw in same cycle as ack: ack wins
    req(4'd5, 8'h40);
    step();
    chk("wa_irq", irq, 1);
    req(4'd0, 8'h00);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("wa_clr", clr, 1);
    chk("wa_clrvec", clr_vec, 8'h40);
    step();
    step();
    step();
    step();
    chk("wa_idle", busy, 0);

    // hold-off with request held continuously
    req(4'd7, 8'h33);
    step();
    chk("ho_irq", irq, 1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq) break;
      low_cnt++;
      step();
    end
    chk("ho_low_cycles", low_cnt, 2 + HOLD_CYC);
    chk("ho_reissue", irq, 1);
    chk("ho_lvl", irq_lvl, 7);
    chk("ho_vec", irq_vec, 8'h33);

    // reset in HOLD, then pending request re-issues
    cpu_ack = 1'b1;
    step();                                  // CLR
    cpu_ack = 1'b0;
    step();                                  // HOLD
    chk("rh_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rh_irq", irq, 0);
    chk("rh_clr", clr, 0);
    chk("rh_clrvec", clr_vec, 0);
    chk("rh_lvl", irq_lvl, 0);
    chk("rh_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rh_reissue", irq, 1);
    chk("rh_relvl", irq_lvl, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
